// File: rtl/idli_decode_buf_m.sv
// idli_decode_buf_m: assembles SQI beats into 16b words, tags immediates and
// queues them in a small FIFO for the decoder.
module idli_decode_buf_m #(
    parameter int LANE_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_db_gck,
    input  logic              i_db_rst,
    input  logic [LANE_W-1:0] i_db_lane,
    input  logic              i_db_lane_vld,
    input  logic              i_db_flush,
    input  logic              i_db_pop,
    output logic [15:0]       o_db_enc,
    output logic              o_db_vld,
    output logic              o_db_imm,
    output logic [CNT_W-1:0]  o_db_cnt,
    output logic              o_db_rdy,
    output logic              o_db_ovf
);
    localparam int BEATS = 16 / LANE_W;
    localparam int BW    = $clog2(BEATS);
    localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [BW-1:0]      beat;
    logic [15-LANE_W:0] part;
    logic               imm_pend;
    logic [16:0]        mem [DEPTH];
    logic [PW-1:0]      rd, wr, hd;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic [15:0]        word;
    logic               done, full, pop_ok, push, set_pend;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] dec(input logic [PW-1:0] p);
        return p == '0 ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign word     = {part, i_db_lane};
    assign done     = i_db_lane_vld && beat == BW'(BEATS - 1);
    assign full     = cnt == CNT_W'(DEPTH);
    assign pop_ok   = i_db_pop && cnt != '0;
    assign push     = done && (!full || pop_ok);
    assign set_pend = !imm_pend && word[3:0] == 4'hF && word[15:13] != 3'b100 &&
                      !(word[15:12] == 4'b1101 && !word[4]);

    // When empty, show the entry just behind the read pointer so the last word holds
    assign hd       = cnt != '0 ? rd : dec(rd);
    assign o_db_enc = mem[hd][15:0];
    assign o_db_vld = cnt != '0;
    assign o_db_imm = o_db_vld && mem[hd][16];
    assign o_db_cnt = cnt;
    assign o_db_rdy = !full;
    assign o_db_ovf = ovf;

    always_ff @(posedge i_db_gck or posedge i_db_rst) begin
        if (i_db_rst) begin
            beat     <= '0;
            part     <= '0;
            imm_pend <= 1'b0;
            rd       <= '0;
            wr       <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_db_flush) begin
            beat     <= '0;
            imm_pend <= 1'b0;
            cnt      <= '0;
            ovf      <= 1'b0;
            // Step past the visible head so the empty-hold view keeps showing it
            if (cnt != '0) begin
                rd <= inc(rd);
                wr <= inc(rd);
            end
        end else begin
            if (i_db_lane_vld) begin
                beat <= done ? '0 : beat + 1'b1;
                part <= word[15-LANE_W:0];
            end
            if (done) imm_pend <= set_pend;
            if (push) begin
                mem[wr] <= {imm_pend, word};
                wr      <= inc(wr);
            end
            if (pop_ok) rd <= inc(rd);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop_ok);
            if (done && !push) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_idli_decode_buf_m.sv
// tb_idli_decode_buf_m: scoreboard bench for the 4-lane/2-deep buffer plus
// directed checks of a 1-lane/1-deep buffer including async reset.
module tb_idli_decode_buf_m;
    logic        clk = 0, rst = 1, lv = 0, flush = 0, pop = 0;
    logic [3:0]  lane = 0;
    logic [15:0] enc;
    logic        vld, imm, rdy, ovf;
    logic [1:0]  cnt;

    logic        rst2 = 1, lv2 = 0, pop2 = 0, lane2 = 0;
    logic [15:0] enc2;
    logic        vld2, imm2, rdy2, ovf2;
    logic        cnt2;

    int          checks = 0, failures = 0;
    logic [16:0] q[$];
    int          mbeat = 0;
    int          mword = 0;
    bit          mpend = 0, movf = 0;

    always #5 clk = ~clk;

    idli_decode_buf_m u_a (
        .i_db_gck(clk), .i_db_rst(rst), .i_db_lane(lane), .i_db_lane_vld(lv),
        .i_db_flush(flush), .i_db_pop(pop), .o_db_enc(enc), .o_db_vld(vld),
        .o_db_imm(imm), .o_db_cnt(cnt), .o_db_rdy(rdy), .o_db_ovf(ovf)
    );

    idli_decode_buf_m #(.LANE_W(1), .DEPTH(1)) u_b (
        .i_db_gck(clk), .i_db_rst(rst2), .i_db_lane(lane2), .i_db_lane_vld(lv2),
        .i_db_flush(1'b0), .i_db_pop(pop2), .o_db_enc(enc2), .o_db_vld(vld2),
        .o_db_imm(imm2), .o_db_cnt(cnt2), .o_db_rdy(rdy2), .o_db_ovf(ovf2)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    function automatic bit sets_imm(input int w);
        return w % 16 == 15 && w / 8192 != 4 && !(w / 4096 == 13 && (w / 16) % 2 == 0);
    endfunction

    // Reference model: stream of words, pending-immediate flag and an ideal bounded queue
    initial forever begin
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            mbeat = 0;
            mpend = 0;
            movf  = 0;
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (lv) begin
                mword = (mword * 16 + int'(lane)) % 65536;
                mbeat++;
                if (mbeat == 4) begin
                    mbeat = 0;
                    if (q.size() < 2) q.push_back({mpend, 16'(mword)});
                    else movf = 1;
                    mpend = !mpend && sets_imm(mword);
                end
            end
        end
    end

    // Monitor: compares the DUT's presented head and status with the model
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("sb_cnt", 32'(cnt), q.size());
            chk("sb_vld", 32'(vld), 32'(q.size() != 0));
            chk("sb_rdy", 32'(rdy), 32'(q.size() < 2));
            chk("sb_ovf", 32'(ovf), 32'(movf));
            if (vld && q.size() != 0) begin
                chk("sb_enc", 32'(enc), 32'(q[0][15:0]));
                chk("sb_imm", 32'(imm), 32'(q[0][16]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] l, input logic p, input logic f);
        lane = l; lv = 1; pop = p; flush = f;
        tick();
        lv = 0; pop = 0; flush = 0;
    endtask

    task automatic send(input logic [15:0] w, input logic [3:0] pm);
        for (int i = 0; i < 4; i++) beat(w[15-4*i -: 4], pm[i], 1'b0);
    endtask

    task automatic pop_one();
        pop = 1;
        tick();
        pop = 0;
    endtask

    task automatic bit2(input logic b);
        lane2 = b; lv2 = 1;
        tick();
        lv2 = 0;
    endtask

    task automatic send2(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            bit2(w[15-i]);
        end
    endtask

    logic [15:0] ws [10] = '{16'h012F, 16'hFFFF, 16'h0000, 16'h812F, 16'h1234,
                             16'hD0EF, 16'h5555, 16'hD01F, 16'h5555, 16'h0123};
    logic        ie [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_vld", 32'(vld), 0);
        chk("rst_enc", 32'(enc), 0);
        chk("rst_imm", 32'(imm), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_rdy", 32'(rdy), 1);
        chk("rst_ovf", 32'(ovf), 0);

        send(16'h0123, 4'b0000);
        chk("first_enc", 32'(enc), 32'h0123);
        chk("first_vld", 32'(vld), 1);
        chk("first_cnt", 32'(cnt), 1);
        pop_one();
        chk("pop_vld", 32'(vld), 0);
        chk("pop_cnt", 32'(cnt), 0);
        chk("hold_enc", 32'(enc), 32'h0123);

        for (int i = 0; i < 10; i++) begin
            send(ws[i], 4'b0000);
            chk("tag_enc", 32'(enc), 32'(ws[i]));
            chk("tag_imm", 32'(imm), 32'(ie[i]));
            pop_one();
        end

        send(16'h1111, 4'b0000);
        send(16'h2222, 4'b0000);
        chk("full_cnt", 32'(cnt), 2);
        chk("full_rdy", 32'(rdy), 0);
        send(16'hAAAA, 4'b0000);
        chk("drop_ovf", 32'(ovf), 1);
        chk("drop_head", 32'(enc), 32'h1111);
        chk("drop_cnt", 32'(cnt), 2);

        beat(4'h0, 1'b0, 1'b1);
        send(16'h1111, 4'b0000);
        send(16'h2222, 4'b0000);
        send(16'hAAAA, 4'b1000);
        chk("pp_ovf", 32'(ovf), 0);
        chk("pp_cnt", 32'(cnt), 2);
        chk("pp_head", 32'(enc), 32'h2222);

        beat(4'h1, 1'b0, 1'b0);
        beat(4'h2, 1'b0, 1'b0);
        beat(4'h3, 1'b1, 1'b1);
        chk("fl_cnt", 32'(cnt), 0);
        chk("fl_vld", 32'(vld), 0);
        chk("fl_ovf", 32'(ovf), 0);
        send(16'h9876, 4'b0000);
        chk("fl_enc", 32'(enc), 32'h9876);
        pop_one();

        repeat (3000) begin
            lane  = 4'($urandom);
            lv    = $urandom_range(0, 9) < 7;
            pop   = $urandom_range(0, 9) < 4;
            flush = $urandom_range(0, 49) == 0;
            tick();
        end
        lv = 0; pop = 0; flush = 0;
        tick();

        rst2 = 0;
        send2(16'hC3A5, 16);
        chk("b_enc", 32'(enc2), 32'hC3A5);
        chk("b_vld", 32'(vld2), 1);
        chk("b_cnt", 32'(cnt2), 1);
        chk("b_imm", 32'(imm2), 0);
        send2(16'hFFFF, 16);
        chk("b_ovf", 32'(ovf2), 1);
        chk("b_head", 32'(enc2), 32'hC3A5);
        send2(16'h1234, 7);
        #2 rst2 = 1;
        #1;
        chk("ar_vld", 32'(vld2), 0);
        chk("ar_enc", 32'(enc2), 0);
        chk("ar_imm", 32'(imm2), 0);
        chk("ar_cnt", 32'(cnt2), 0);
        chk("ar_rdy", 32'(rdy2), 1);
        chk("ar_ovf", 32'(ovf2), 0);
        tick();
        rst2 = 0;
        send2(16'h5A5A, 16);
        chk("ar_word", 32'(enc2), 32'h5A5A);
        chk("ar_word_imm", 32'(imm2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
